mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  E-stage multiply/divide unit of the pipelined MIPS core. Consumes the forwarded rs/rt operands
//  (GRF read ports after forwarding muxes) and owns the HI/LO registers. MFHI/MFLO results return
//  through the E/M/W pipeline to the GRF write port. Multi-cycle; the hazard unit stalls D on busy.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  MDU_clk_E_i    in   1   clock, rising edge
//  MDU_re_E_i     in   1   reset, asynchronous, active-high
//  MDU_start_E_i  in   1   E-stage instr is an MDU op this cycle (qualifies op)
//  MDU_op_E_i     in   3   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MFHI,7 MFLO
//  MDU_A_E_i      in   32  rs operand (forwarded)
//  MDU_B_E_i      in   32  rt operand (forwarded)
//  MDU_busy_E_o   out  1   operation in progress
//  MDU_stall_E_o  out  1   busy | (start & op in 0..3); to hazard unit
//  MDU_rd_E_o     out  32  MFHI ? HI : LO (combinational from registers)
//  MDU_hi_E_o     out  32  HI register (debug/trace)
//  MDU_lo_E_o     out  32  LO register
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): HI=0, LO=0, counter=0, busy=0, pending result
//    discarded. All outputs 0 while reset held.
//  - Idle (counter==0), start & op 0..3 at edge t: latch 64-bit result into pending regs,
//    counter <= MULT_CYCLES or DIV_CYCLES. busy high cycles t+1 .. t+N.
//  - Each edge with counter!=0: counter--. On the edge counter goes 1->0: {HI,LO} <= pending;
//    busy falls in the same cycle new HI/LO become visible. No intermediate HI/LO update.
//  - MULT: signed 32x32->64, HI=[63:32], LO=[31:0]. MULTU: unsigned.
//  - DIV: signed, LO=quotient trunc toward zero, HI=remainder with sign of dividend.
//    DIVU: unsigned. Divide by zero: counter still loads, HI/LO left unchanged at commit.
//    0x80000000 / -1 (DIV): LO=0x80000000, HI=0.
//  - MTHI/MTLO (idle): HI or LO <= A at the edge, 1-cycle, busy stays 0.
//  - MFHI/MFLO: pure read, no state change; selection from op only (valid regardless of start).
//  - start while busy: ignored (no state change); hazard unit must hold the instr via stall.
//    MTHI/MTLO while busy likewise ignored.
//  - MDU_stall_E_o combinational so the issuing cycle also stalls younger MFHI/MFLO/MDU ops.
//  - Op codes 4..7 never set busy; op decode invalid codes impossible (3-bit fully used).
// STRUCTURE
//  - Op encoding localparams (MDU_MULT..MDU_MFLO) live in the shared core defines header, used
//    by controller and this block.
//  - One natural sub-module: mdu_arith (combinational 64-bit mult/div result from A,B,op incl.
//    div-by-zero flag). Counter, pending regs, HI/LO and stall logic stay in this module.
// TESTING
//  1 MULT A=0xFFFFFFFF B=2 -> busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; unchanged before.
//  2 MULTU A=0xFFFFFFFF B=2 -> HI=0x00000001 LO=0xFFFFFFFE after 5 busy cycles.
//  3 DIV A=-7 B=2 -> after 10 busy cycles LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU 7/2 -> LO=3 HI=1.
//  4 MTHI A=0x1234, DIV B=0 -> busy 10 cycles, HI stays 0x1234; MFHI rd_o=0x1234.
//  5 MULT then start MTLO A=5 while busy -> ignored, LO=product at commit; stall_o high throughout.
//  6 Reset asserted mid-DIV (cycle 4) -> busy=0, HI=LO=0 immediately; no late commit after release.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes, default
// latencies and the 64-bit {HI,LO} result record.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MFHI  = 3'd6,
    MDU_MFLO  = 3'd7
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  // Ops 0..3 are the multi-cycle arithmetic group; 4..7 are register moves.
  function automatic logic mdu_is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage operand/result bundle between the pipeline and the multiply/divide unit.
interface mult_div_unit_if;
  logic        MDU_start_E_i;
  logic [2:0]  MDU_op_E_i;
  logic [31:0] MDU_A_E_i;
  logic [31:0] MDU_B_E_i;
  logic        MDU_busy_E_o;
  logic        MDU_stall_E_o;
  logic [31:0] MDU_rd_E_o;
  logic [31:0] MDU_hi_E_o;
  logic [31:0] MDU_lo_E_o;

  modport slave (
    input  MDU_start_E_i, MDU_op_E_i, MDU_A_E_i, MDU_B_E_i,
    output MDU_busy_E_o, MDU_stall_E_o, MDU_rd_E_o, MDU_hi_E_o, MDU_lo_E_o
  );

  modport master (
    output MDU_start_E_i, MDU_op_E_i, MDU_A_E_i, MDU_B_E_i,
    input  MDU_busy_E_o, MDU_stall_E_o, MDU_rd_E_o, MDU_hi_E_o, MDU_lo_E_o
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply / divide datapath. Division works on magnitudes
// and re-applies signs so the quotient truncates toward zero.
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output mdu_res_t    res_o,
  output logic        dz_o
);

  logic        sgn;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;

  always_comb begin
    sgn   = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    prod  = sgn ? ({{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i})
                : ({32'b0, a_i} * {32'b0, b_i});
    a_mag = (sgn && a_i[31]) ? -a_i : a_i;
    b_mag = (sgn && b_i[31]) ? -b_i : b_i;
    // Divisor forced non-zero so the datapath never yields X; the commit is
    // suppressed anyway when dz_o is set.
    b_safe = (b_i == 32'b0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    dz_o   = (b_i == 32'b0);

    if (op_i[1]) begin
      res_o.lo = (sgn && (a_i[31] ^ b_i[31])) ? -q_mag : q_mag;
      res_o.hi = (sgn && a_i[31]) ? -r_mag : r_mag;
    end else begin
      res_o.hi = prod[63:32];
      res_o.lo = prod[31:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/DIV as fixed-latency
// operations and raises stall so the hazard unit holds younger MDU users.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic           MDU_clk_E_i,
  input  logic           MDU_re_E_i,
  mult_div_unit_if.slave bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_res_t         pend_q, pend_d;
  logic             pend_dz_q, pend_dz_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  mdu_res_t arith_res;
  logic     arith_dz;
  logic     busy, issue;

  mdu_arith u_arith (
    .op_i  (bus.MDU_op_E_i),
    .a_i   (bus.MDU_A_E_i),
    .b_i   (bus.MDU_B_E_i),
    .res_o (arith_res),
    .dz_o  (arith_dz)
  );

  assign busy  = (cnt_q != '0);
  assign issue = bus.MDU_start_E_i && mdu_is_arith(bus.MDU_op_E_i);

  always_comb begin
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (busy) begin
      // New ops are ignored while busy; only the countdown and final commit happen.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && !pend_dz_q) begin
        hi_d = pend_q.hi;
        lo_d = pend_q.lo;
      end
    end else if (issue) begin
      cnt_d     = bus.MDU_op_E_i[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      pend_d    = arith_res;
      pend_dz_d = bus.MDU_op_E_i[1] && arith_dz;
    end else if (bus.MDU_start_E_i && bus.MDU_op_E_i == MDU_MTHI) begin
      hi_d = bus.MDU_A_E_i;
    end else if (bus.MDU_start_E_i && bus.MDU_op_E_i == MDU_MTLO) begin
      lo_d = bus.MDU_A_E_i;
    end
  end

  always_ff @(posedge MDU_clk_E_i or posedge MDU_re_E_i) begin
    if (MDU_re_E_i) begin
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.MDU_busy_E_o  = busy;
  assign bus.MDU_stall_E_o = !MDU_re_E_i && (busy || issue);
  assign bus.MDU_rd_E_o    = (bus.MDU_op_E_i == MDU_MFHI) ? hi_q : lo_q;
  assign bus.MDU_hi_E_o    = hi_q;
  assign bus.MDU_lo_E_o    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences and random traffic against a cycle-stamped reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic rst;
  mult_div_unit_if bus ();

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .MDU_clk_E_i (clk),
    .MDU_re_E_i  (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural HI/LO plus the edge index at which the
  // outstanding operation commits (busy while that edge lies in the future).
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  bit          m_pend_ok;
  int          m_done;
  int          cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat(input logic [2:0] op);
    return op[1] ? DC : MC;
  endfunction

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  function automatic bit m_busy();
    return m_done > cyc;
  endfunction

  // One cycle: drive, check the combinational view against the model, clock, update model.
  task automatic step(input logic start, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit was_busy;
    bus.MDU_start_E_i = start;
    bus.MDU_op_E_i    = op;
    bus.MDU_A_E_i     = a;
    bus.MDU_B_E_i     = b;
    #1;
    was_busy = m_busy();
    chk("busy",  32'(bus.MDU_busy_E_o),  32'(was_busy));
    chk("stall", 32'(bus.MDU_stall_E_o), 32'(was_busy || (start && op < 3'd4)));
    chk("hi",    bus.MDU_hi_E_o, m_hi);
    chk("lo",    bus.MDU_lo_E_o, m_lo);
    chk("rd",    bus.MDU_rd_E_o, (op == 3'd6) ? m_hi : m_lo);
    @(posedge clk);
    cyc++;
    if (was_busy) begin
      if (m_done == cyc && m_pend_ok) {m_hi, m_lo} = m_pend;
    end else if (start && op < 3'd4) begin
      m_done    = cyc + lat(op);
      m_pend_ok = !(op[1] && b == 32'b0);
      m_pend    = m_pend_ok ? ref_res(op, a, b) : 64'b0;
    end else if (start && op == 3'd4) begin
      m_hi = a;
    end else if (start && op == 3'd5) begin
      m_lo = a;
    end
    #1;
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_pend = '0; m_pend_ok = 0; m_done = -1;
  endtask

  // Idles until the unit drops busy; returns the number of busy cycles seen.
  task automatic drain(output int nb);
    nb = 0;
    while (bus.MDU_busy_E_o && nb < 50) begin
      nb++;
      step(0, 3'd6, 32'h0, 32'h0);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[9];
  int   nb;

  initial begin
    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{3'd3, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF};
    vecs[8] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    cyc = 0;
    model_reset();
    bus.MDU_start_E_i = 1'b1;
    bus.MDU_op_E_i    = 3'd0;
    bus.MDU_A_E_i     = 32'h0;
    bus.MDU_B_E_i     = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(bus.MDU_busy_E_o),  32'd0);
    chk("rst_stall", 32'(bus.MDU_stall_E_o), 32'd0);
    chk("rst_hi",    bus.MDU_hi_E_o, 32'h0);
    chk("rst_lo",    bus.MDU_lo_E_o, 32'h0);
    rst = 1'b0;

    // Directed table; HI/LO preloaded so "unchanged before commit" is visible.
    foreach (vecs[i]) begin
      step(1, 3'd4, 32'hA5A5_0000 + 32'(i), 32'h0);
      step(1, 3'd5, 32'h5A5A_0000 + 32'(i), 32'h0);
      step(1, vecs[i].op, vecs[i].a, vecs[i].b);
      drain(nb);
      chk($sformatf("vec%0d_lat", i), 32'(nb), 32'(lat(vecs[i].op)));
      chk($sformatf("vec%0d_hi", i), bus.MDU_hi_E_o, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.MDU_lo_E_o, vecs[i].lo);
    end

    // MTHI then DIV by zero: latency still applies, HI/LO untouched.
    step(1, 3'd4, 32'h1234, 32'h0);
    step(1, 3'd5, 32'h5678, 32'h0);
    step(1, 3'd2, 32'd99, 32'h0);
    drain(nb);
    chk("dz_lat", 32'(nb), 32'(DC));
    bus.MDU_op_E_i = 3'd6;
    #1;
    chk("dz_mfhi", bus.MDU_rd_E_o, 32'h1234);
    chk("dz_lo",   bus.MDU_lo_E_o, 32'h5678);

    // MTLO presented while a MULT is in flight must be dropped.
    step(1, 3'd0, 32'd3, 32'd4);
    nb = 0;
    while (bus.MDU_busy_E_o && nb < 50) begin
      nb++;
      chk("hold_stall", 32'(bus.MDU_stall_E_o), 32'd1);
      step(1, 3'd5, 32'd5, 32'h0);
    end
    chk("hold_lat", 32'(nb), 32'(MC));
    chk("hold_lo",  bus.MDU_lo_E_o, 32'd12);
    chk("hold_hi",  bus.MDU_hi_E_o, 32'd0);

    // Async reset in the middle of a DIV: clears at once, no late commit.
    step(1, 3'd2, 32'd100, 32'd7);
    repeat (3) step(0, 3'd7, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_busy", 32'(bus.MDU_busy_E_o), 32'd0);
    chk("mid_rst_hi",   bus.MDU_hi_E_o, 32'h0);
    chk("mid_rst_lo",   bus.MDU_lo_E_o, 32'h0);
    @(posedge clk);
    cyc++;
    #3 rst = 1'b0;
    repeat (DC + 3) step(0, 3'd7, 32'h0, 32'h0);

    // Random traffic, including corner operands and back-to-back issue attempts.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: a = 32'($signed(-$urandom_range(1, 100)));
        default: ;
      endcase
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
